// File: rtl/vga_plot_arbiter_if.sv
// Drawer-side request/pixel bundle and VGA-side pixel output of the plot arbiter.
interface vga_plot_arbiter_if #(
  parameter int N_REQ = 3,
  parameter int X_W   = 9,
  parameter int Y_W   = 8,
  parameter int C_W   = 3
);
  localparam int OW = $clog2(N_REQ);

  logic [N_REQ-1:0]     req;
  logic [N_REQ-1:0]     pvalid;
  logic [N_REQ-1:0]     last;
  logic [N_REQ-1:0]     erase;
  logic [N_REQ*X_W-1:0] px;
  logic [N_REQ*Y_W-1:0] py;
  logic [N_REQ*C_W-1:0] pcol;
  logic [N_REQ-1:0]     gnt;
  logic [OW-1:0]        owner;
  logic                 busy;
  logic [X_W-1:0]       x_out;
  logic [Y_W-1:0]       y_out;
  logic [C_W-1:0]       colour_out;
  logic                 plot;
  logic                 timeout;

  modport slave (
    input  req, pvalid, last, erase, px, py, pcol,
    output gnt, owner, busy, x_out, y_out, colour_out, plot, timeout
  );

  modport master (
    output req, pvalid, last, erase, px, py, pcol,
    input  gnt, owner, busy, x_out, y_out, colour_out, plot, timeout
  );
endinterface

// File: rtl/vga_plot_arbiter.sv
// Rotating-priority arbiter sharing the VGA pixel-write port between sprite drawers.
// Define ARB_WATCHDOG_EN to force-release bursts that run MAX_BURST granted cycles.
module vga_plot_arbiter #(
  parameter int             N_REQ     = 3,
  parameter int             X_W       = 9,
  parameter int             Y_W       = 8,
  parameter int             C_W       = 3,
  parameter logic [C_W-1:0] BG_COLOUR = '0,
  parameter int             MAX_BURST = 1023
) (
  input logic               clock,
  input logic               reset,
  vga_plot_arbiter_if.slave bus
);
  localparam int OW = $clog2(N_REQ);

  typedef enum logic [1:0] {IDLE = 2'd0, GRANT = 2'd1, HOLDOFF = 2'd2} state_t;

  state_t         state_q, state_d;
  logic [OW-1:0]  owner_q, owner_d, rr_q, rr_d, pick, owner_inc;
  logic           found;
  logic [X_W-1:0] x_q, x_d;
  logic [Y_W-1:0] y_q, y_d;
  logic [C_W-1:0] colour_q, colour_d;
  logic           plot_q, plot_d, timeout_q, timeout_d;
  logic [N_REQ-1:0] gnt;
  logic             busy;

  logic [X_W-1:0] px_arr   [N_REQ];
  logic [Y_W-1:0] py_arr   [N_REQ];
  logic [C_W-1:0] pcol_arr [N_REQ];

  genvar gi;
  generate
    if (N_REQ < 2 || N_REQ > 8 || MAX_BURST < 1) begin : g_bad_cfg
      $error("vga_plot_arbiter: unsupported N_REQ or MAX_BURST");
    end
    for (gi = 0; gi < N_REQ; gi++) begin : g_unpack
      assign px_arr[gi]   = bus.px[gi*X_W +: X_W];
      assign py_arr[gi]   = bus.py[gi*Y_W +: Y_W];
      assign pcol_arr[gi] = bus.pcol[gi*C_W +: C_W];
    end
  endgenerate

  logic o_req, o_valid, o_last, o_erase;
  logic take_last, wd_fire, wd_rel, abort, release_burst, accept;

  assign o_req     = bus.req[owner_q];
  assign o_valid   = bus.pvalid[owner_q];
  assign o_last    = bus.last[owner_q];
  assign o_erase   = bus.erase[owner_q];
  assign owner_inc = (owner_q == OW'(N_REQ - 1)) ? '0 : owner_q + OW'(1);

  // A final pixel beats both an owner req drop and a watchdog expiry in the same cycle.
  assign take_last     = o_valid && o_last;
  assign wd_rel        = wd_fire && !take_last;
  assign abort         = !o_req && !take_last;
  assign release_burst = take_last || abort || wd_rel;
  assign accept        = o_valid && (take_last || (o_req && !wd_fire));

`ifdef ARB_WATCHDOG_EN
  localparam int CW = $clog2(MAX_BURST + 1);
  logic [CW-1:0] cnt_q, cnt_d;

  assign wd_fire = (state_q == GRANT) && (cnt_q == CW'(MAX_BURST - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (state_q == IDLE) cnt_d = '0;
    else if (state_q == GRANT) cnt_d = cnt_q + CW'(1);
  end

  always_ff @(posedge clock) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end
`else
  assign wd_fire = 1'b0;
`endif

  // Scan from rr upward with wrap; descending loop so the nearest requester wins.
  always_comb begin
    int          idx;
    logic [OW-1:0] idx_w;
    pick  = '0;
    found = 1'b0;
    idx   = 0;
    idx_w = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      idx = int'(rr_q) + i;
      if (idx >= N_REQ) idx = idx - N_REQ;
      idx_w = OW'(idx);
      if (bus.req[idx_w]) begin
        pick  = idx_w;
        found = 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= IDLE;
      owner_q   <= '0;
      rr_q      <= '0;
      x_q       <= '0;
      y_q       <= '0;
      colour_q  <= '0;
      plot_q    <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      rr_q      <= rr_d;
      x_q       <= x_d;
      y_q       <= y_d;
      colour_q  <= colour_d;
      plot_q    <= plot_d;
      timeout_q <= timeout_d;
    end
  end

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    rr_d    = rr_q;
    unique case (state_q)
      IDLE: begin
        if (found) begin
          state_d = GRANT;
          owner_d = pick;
        end
      end
      GRANT: begin
        if (release_burst) begin
          state_d = HOLDOFF;
          rr_d    = owner_inc;
        end
      end
      HOLDOFF: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    x_d       = x_q;
    y_d       = y_q;
    colour_d  = colour_q;
    plot_d    = 1'b0;
    timeout_d = 1'b0;
    if (state_q == GRANT) begin
      timeout_d = wd_rel;
      if (accept) begin
        plot_d   = 1'b1;
        x_d      = px_arr[owner_q];
        y_d      = py_arr[owner_q];
        colour_d = o_erase ? BG_COLOUR : pcol_arr[owner_q];
      end
    end
    gnt  = (state_q == GRANT) ? (N_REQ'(1) << owner_q) : '0;
    busy = (state_q != IDLE);
  end

  assign bus.gnt        = gnt;
  assign bus.owner      = owner_q;
  assign bus.busy       = busy;
  assign bus.x_out      = x_q;
  assign bus.y_out      = y_q;
  assign bus.colour_out = colour_q;
  assign bus.plot       = plot_q;
  assign bus.timeout    = timeout_q;
endmodule

// File: tb/tb_vga_plot_arbiter.sv
// Scoreboard bench for vga_plot_arbiter: stimulus queues expected pixels and grants,
// a negedge monitor pops and compares them as the DUT presents plot pulses and new grants.
module tb_vga_plot_arbiter;
  localparam int N  = 3;
  localparam int XW = 9;
  localparam int YW = 8;
  localparam int CW = 3;

  typedef struct {
    int x;
    int y;
    int c;
  } pix_t;

  logic clock = 1'b0;
  logic reset;
  int   n_cmp = 0;
  int   n_err = 0;
  pix_t exp_pix[$];
  int   exp_gnt[$];
  logic [N-1:0] prev_gnt = '0;

  vga_plot_arbiter_if #(.N_REQ(N), .X_W(XW), .Y_W(YW), .C_W(CW)) bus ();

  vga_plot_arbiter #(
    .N_REQ(N), .X_W(XW), .Y_W(YW), .C_W(CW), .BG_COLOUR(3'b000), .MAX_BURST(8)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: one line per observed transaction.
  always @(negedge clock) begin
    if (bus.plot === 1'b1) begin
      if (exp_pix.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_plot: got x=%0d y=%0d c=%0d expected none", bus.x_out, bus.y_out, bus.colour_out);
      end else begin
        pix_t p;
        p = exp_pix.pop_front();
        $display("plot x=%0d y=%0d c=%0d", bus.x_out, bus.y_out, bus.colour_out);
        chk("pixel_x", 32'(bus.x_out), p.x);
        chk("pixel_y", 32'(bus.y_out), p.y);
        chk("pixel_colour", 32'(bus.colour_out), p.c);
      end
    end
    if (bus.gnt != '0 && prev_gnt == '0) begin
      if (exp_gnt.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_grant: got gnt=%b expected none", bus.gnt);
      end else begin
        int o;
        o = exp_gnt.pop_front();
        $display("grant gnt=%b owner=%0d", bus.gnt, bus.owner);
        chk("grant_onehot", 32'(bus.gnt), 32'(1) << o);
        chk("grant_owner", 32'(bus.owner), o);
      end
    end
    prev_gnt = bus.gnt;
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drive_pix(input int r, input bit v, input bit l, input int x, input int y,
                           input int c, input bit e);
    bus.pvalid[r] = v;
    bus.last[r]   = l;
    bus.erase[r]  = e;
    bus.px[r*XW +: XW] = XW'(x);
    bus.py[r*YW +: YW] = YW'(y);
    bus.pcol[r*CW +: CW] = CW'(c);
  endtask

  task automatic clear_pix();
    for (int o = 0; o < N; o++) drive_pix(o, 1'b0, 1'b0, 0, 0, 0, 1'b0);
  endtask

  task automatic wait_gnt(input int r);
    for (int k = 0; k < 12; k++) begin
      if (bus.gnt[r]) break;
      tick();
    end
    chk($sformatf("gnt_wait_%0d", r), 32'(bus.gnt[r]), 1);
  endtask

  task automatic push_pix(input int x, input int y, input int c);
    pix_t p;
    p.x = x;
    p.y = y;
    p.c = c;
    exp_pix.push_back(p);
  endtask

  // Complete burst by requester r; optional noise from non-owners that must never plot.
  task automatic run_burst(input int r, input int n, input int x0, input int y0, input int c,
                           input bit e, input bit noise);
    wait_gnt(r);
    if (noise) begin
      for (int o = 0; o < N; o++) if (o != r) drive_pix(o, 1'b1, 1'b1, 400 + o, 200, 7, 1'b0);
      tick();
      chk("nonowner_plot", 32'(bus.plot), 0);
    end
    for (int k = 0; k < n; k++) begin
      drive_pix(r, 1'b1, k == n - 1, x0 + k, y0, c, e);
      push_pix(x0 + k, y0, e ? 0 : c);
      tick();
      chk("plot_latency", 32'(bus.plot), 1);
    end
    chk("gnt_release", 32'(bus.gnt), 0);
    chk("busy_holdoff", 32'(bus.busy), 1);
    clear_pix();
  endtask

  initial begin
    reset      = 1'b1;
    bus.req    = '0;
    bus.pvalid = '0;
    bus.last   = '0;
    bus.erase  = '0;
    bus.px     = '0;
    bus.py     = '0;
    bus.pcol   = '0;
    tick();
    chk("rst_gnt", 32'(bus.gnt), 0);
    chk("rst_plot", 32'(bus.plot), 0);
    chk("rst_busy", 32'(bus.busy), 0);
    chk("rst_owner", 32'(bus.owner), 0);
    chk("rst_timeout", 32'(bus.timeout), 0);
    tick();
    reset = 1'b0;

    // Single burst from requester 1
    bus.req = 3'b010;
    exp_gnt.push_back(1);
    chk("gnt_before_edge", 32'(bus.gnt), 0);
    tick();
    chk("gnt_latency", 32'(bus.gnt), 3'b010);
    chk("busy_grant", 32'(bus.busy), 1);
    run_burst(1, 4, 10, 5, 3'b101, 1'b0, 1'b0);
    bus.req = 3'b000;
    tick();
    chk("idle_busy", 32'(bus.busy), 0);
    chk("idle_gnt", 32'(bus.gnt), 0);

    // Round robin from a fresh reset
    reset = 1'b1;
    tick();
    reset   = 1'b0;
    bus.req = 3'b111;
    exp_gnt.push_back(0);
    exp_gnt.push_back(1);
    exp_gnt.push_back(2);
    run_burst(0, 2, 100, 1, 1, 1'b0, 1'b0);
    run_burst(1, 2, 110, 2, 2, 1'b0, 1'b0);
    run_burst(2, 2, 120, 3, 3, 1'b0, 1'b0);
    bus.req = 3'b101;
    exp_gnt.push_back(0);
    exp_gnt.push_back(2);
    exp_gnt.push_back(0);
    run_burst(0, 2, 130, 4, 4, 1'b0, 1'b0);
    run_burst(2, 2, 140, 5, 5, 1'b0, 1'b0);
    run_burst(0, 2, 150, 6, 6, 1'b0, 1'b0);
    bus.req = 3'b000;
    tick();

    // Erase forces background colour; non-owner pixels ignored
    bus.req = 3'b001;
    exp_gnt.push_back(0);
    run_burst(0, 3, 20, 30, 3'b110, 1'b1, 1'b1);
    bus.req = 3'b000;
    tick();

    // Abort after 2 of 5 pixels
    bus.req = 3'b100;
    exp_gnt.push_back(2);
    wait_gnt(2);
    for (int k = 0; k < 2; k++) begin
      drive_pix(2, 1'b1, 1'b0, 50 + k, 60, 3, 1'b0);
      push_pix(50 + k, 60, 3);
      tick();
      chk("abort_plot_latency", 32'(bus.plot), 1);
    end
    drive_pix(2, 1'b1, 1'b0, 52, 60, 3, 1'b0);
    bus.req = 3'b000;
    tick();
    chk("abort_gnt", 32'(bus.gnt), 0);
    chk("abort_busy", 32'(bus.busy), 1);
    chk("abort_plot", 32'(bus.plot), 0);
    clear_pix();
    bus.req = 3'b101;
    exp_gnt.push_back(0);
    run_burst(0, 1, 70, 71, 2, 1'b0, 1'b0);
    bus.req = 3'b000;
    tick();

    // Reset held 2 cycles mid-burst discards in-flight pixel and rr
    bus.req = 3'b100;
    exp_gnt.push_back(2);
    wait_gnt(2);
    drive_pix(2, 1'b1, 1'b0, 80, 81, 4, 1'b0);
    reset = 1'b1;
    tick();
    chk("midrst_gnt", 32'(bus.gnt), 0);
    chk("midrst_plot", 32'(bus.plot), 0);
    chk("midrst_busy", 32'(bus.busy), 0);
    chk("midrst_owner", 32'(bus.owner), 0);
    chk("midrst_x", 32'(bus.x_out), 0);
    tick();
    chk("midrst_plot2", 32'(bus.plot), 0);
    chk("midrst_busy2", 32'(bus.busy), 0);
    reset = 1'b0;
    clear_pix();
    bus.req = 3'b011;
    exp_gnt.push_back(0);
    run_burst(0, 1, 90, 91, 1, 1'b0, 1'b0);
    bus.req = 3'b000;
    tick();

    // Watchdog: hold req with no last
    bus.req = 3'b010;
    exp_gnt.push_back(1);
    wait_gnt(1);
`ifdef ARB_WATCHDOG_EN
    begin
      int granted;
      granted = 0;
      while (bus.gnt[1] && granted < 30) begin
        granted++;
        tick();
      end
      chk("wd_granted_cycles", granted, 8);
      chk("wd_timeout_pulse", 32'(bus.timeout), 1);
      tick();
      chk("wd_timeout_single", 32'(bus.timeout), 0);
    end
`else
    begin
      bit to_seen;
      to_seen = 1'b0;
      for (int k = 0; k < 20; k++) begin
        tick();
        to_seen = to_seen | bus.timeout;
      end
      chk("nowd_gnt_held", 32'(bus.gnt), 3'b010);
      chk("nowd_timeout", 32'(to_seen), 0);
    end
`endif
    bus.req = 3'b000;
    tick();
    tick();
    tick();
    chk("pix_queue_empty", exp_pix.size(), 0);
    chk("gnt_queue_empty", exp_gnt.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
